// File: rtl/deser_pkg.sv
// Shared types and defaults for the serial deserializer.
package deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/deser_out_reg.sv
// One-entry holding register for completed words with valid/ready and sticky overrun.
module deser_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overrun
);

    logic holder_free;

    // A word consumed on this edge frees the slot for a word completing on the same edge.
    assign holder_free = !word_valid || word_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load && holder_free) begin
                word_out   <= word_in;
                word_valid <= 1'b1;
            end else if (word_ready) begin
                word_valid <= 1'b0;
            end

            if (load && !holder_free) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out word assembler, MSB first, with start-delimited frames.
//   state | meaning
//   IDLE  | waiting for a valid bit qualified by start
//   SHIFT | frame in progress, collecting bits until WIDTH are received
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             start,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("serial_deserializer: WIDTH must be in 2..32");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] next_word;
    logic             first_bit;
    logic             word_done;

    assign next_word = {shift_reg[WIDTH-2:0], bit_in};
    assign first_bit = bit_valid && start;
    assign word_done = (state == SHIFT) && bit_valid && !start && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= '0;
            busy      <= 1'b0;
        end else begin
            if (first_bit) begin
                // Start in either state begins a fresh frame; any partial word is dropped.
                shift_reg <= {{(WIDTH-1){1'b0}}, bit_in};
                count     <= CW'(1);
                state     <= SHIFT;
                busy      <= 1'b1;
            end else if (state == SHIFT && bit_valid) begin
                shift_reg <= next_word;
                if (count == LAST) begin
                    count <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    deser_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (word_done),
        .word_in    (next_word),
        .word_ready (word_ready),
        .ovr_clr    (ovr_clr),
        .word_out   (word_out),
        .word_valid (word_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer with hand-computed expected words.
module tb_serial_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bit_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         start = 1'b0;
    logic         word_ready = 1'b0;
    logic         ovr_clr = 1'b0;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         busy;
    logic         overrun;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int c0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .start      (start),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sends n bits of v, MSB first, start on the first; optional gap after bit gap_at.
    task automatic send_bits(input logic [31:0] v, input int n, input int gap_at,
                             input int gap_len, input logic rdy_last);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = v[n-1-i];
            start     = (i == 0);
            if (rdy_last && i == n - 1) word_ready = 1'b1;
            tick;
            if (n == W && i == n - 1) chk("busy_last", {31'b0, busy}, 32'd0);
            else                      chk("busy_mid", {31'b0, busy}, 32'd1);
            if (gap_len > 0 && i == gap_at - 1) begin
                bit_valid = 1'b0;
                start     = 1'b0;
                repeat (gap_len) begin
                    tick;
                    chk("busy_gap", {31'b0, busy}, 32'd1);
                    chk("valid_gap", {31'b0, word_valid}, 32'd0);
                end
            end
        end
        bit_valid = 1'b0;
        start     = 1'b0;
        if (rdy_last) word_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick;
        tick;
        chk("rst_word", {24'b0, word_out}, 32'h0);
        chk("rst_valid", {31'b0, word_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ovr", {31'b0, overrun}, 32'd0);
        rst_n = 1'b1;
        tick;

        // Single frame, consumer always ready
        word_ready = 1'b1;
        c0 = cyc;
        send_bits(32'hB2, 8, 0, 0, 1'b0);
        chk("f1_lat", cyc - c0, 32'd8);
        chk("f1_valid", {31'b0, word_valid}, 32'd1);
        chk("f1_word", {24'b0, word_out}, 32'hB2);
        tick;
        chk("f1_valid_drop", {31'b0, word_valid}, 32'd0);

        // Gapped input
        c0 = cyc;
        send_bits(32'hB2, 8, 4, 3, 1'b0);
        chk("gap_lat", cyc - c0, 32'd11);
        chk("gap_valid", {31'b0, word_valid}, 32'd1);
        chk("gap_word", {24'b0, word_out}, 32'hB2);
        tick;

        // Restart discards partial prefix
        send_bits(32'h7, 3, 0, 0, 1'b0);
        chk("rs_prefix_valid", {31'b0, word_valid}, 32'd0);
        send_bits(32'h55, 8, 0, 0, 1'b0);
        chk("rs_word", {24'b0, word_out}, 32'h55);
        chk("rs_valid", {31'b0, word_valid}, 32'd1);
        chk("rs_ovr", {31'b0, overrun}, 32'd0);
        tick;

        // Back-pressure and overrun
        word_ready = 1'b0;
        send_bits(32'hA5, 8, 0, 0, 1'b0);
        chk("bp_word1", {24'b0, word_out}, 32'hA5);
        chk("bp_ovr1", {31'b0, overrun}, 32'd0);
        send_bits(32'h3C, 8, 0, 0, 1'b0);
        chk("bp_word2", {24'b0, word_out}, 32'hA5);
        chk("bp_valid2", {31'b0, word_valid}, 32'd1);
        chk("bp_ovr2", {31'b0, overrun}, 32'd1);
        word_ready = 1'b1;
        tick;
        word_ready = 1'b0;
        chk("bp_drain", {31'b0, word_valid}, 32'd0);
        tick;
        chk("bp_ovr_sticky", {31'b0, overrun}, 32'd1);
        ovr_clr = 1'b1;
        tick;
        ovr_clr = 1'b0;
        chk("bp_ovr_clr", {31'b0, overrun}, 32'd0);

        // Overrun set wins over a simultaneous clear
        send_bits(32'h5A, 8, 0, 0, 1'b0);
        ovr_clr = 1'b1;
        send_bits(32'h33, 8, 0, 0, 1'b0);
        chk("pri_ovr", {31'b0, overrun}, 32'd1);
        chk("pri_word", {24'b0, word_out}, 32'h5A);
        tick;
        ovr_clr = 1'b0;
        chk("pri_clr", {31'b0, overrun}, 32'd0);
        word_ready = 1'b1;
        tick;
        word_ready = 1'b0;

        // Consume and complete on the same edge
        send_bits(32'h11, 8, 0, 0, 1'b0);
        chk("sim_hold", {24'b0, word_out}, 32'h11);
        send_bits(32'h22, 8, 0, 0, 1'b1);
        chk("sim_word", {24'b0, word_out}, 32'h22);
        chk("sim_valid", {31'b0, word_valid}, 32'd1);
        chk("sim_ovr", {31'b0, overrun}, 32'd0);
        word_ready = 1'b1;
        tick;
        word_ready = 1'b0;
        chk("sim_drain", {31'b0, word_valid}, 32'd0);

        // Asynchronous reset mid-frame with a held word
        send_bits(32'h44, 8, 0, 0, 1'b0);
        send_bits(32'h16, 5, 0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_word", {24'b0, word_out}, 32'h0);
        chk("ar_valid", {31'b0, word_valid}, 32'd0);
        chk("ar_busy", {31'b0, busy}, 32'd0);
        chk("ar_ovr", {31'b0, overrun}, 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        word_ready = 1'b1;
        send_bits(32'h81, 8, 0, 0, 1'b0);
        chk("ar_next_word", {24'b0, word_out}, 32'h81);
        chk("ar_next_valid", {31'b0, word_valid}, 32'd1);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
